alu_result_fmt: RTL
===================

Name: alu_result_fmt

Overview:
Downstream stage of the ALU in the UART calculator datapath. Captures the 32-bit ALU result on the ALU done pulse and converts it to an ASCII hexadecimal line. The line is an optional '-', then hex digits, then CR LF. Bytes are streamed one at a time into the UART transmitter over a valid/ready handshake.

Parameters:
LZ_SUPPRESS, 1, 1 = suppress leading zero digits (at least one digit is always sent); 0 = always send 8 digits
UPPER_HEX, 1, 1 = digits A-F as 8'h41..46; 0 = a-f as 8'h61..66

Ports:
clk        input   1   system clock
rst        input   1   asynchronous, active-high reset
alu_done   input   1   one-cycle pulse from ALU; result valid in the same cycle
result     input   32  ALU result
dtype      input   4   data type of the finished op: 4'h1 unsigned, 4'h2 signed; any other value is treated as unsigned
tx_ready   input   1   UART TX can accept a byte
tx_data    output  8   ASCII byte to transmit
tx_valid   output  1   tx_data is valid; held until accepted
busy       output  1   a line is being emitted
overrun    output  1   one-cycle pulse when alu_done is dropped while busy

Behaviour:
- Reset: state IDLE; tx_data=8'h00, tx_valid=0, busy=0, overrun=0; capture register, digit counter and "nonzero seen" flag cleared.
- Reset mid-line aborts the line immediately. The next byte accepted by the TX is whatever follows the first post-reset alu_done.
- Capture, in IDLE when alu_done=1:
  - neg = (dtype==4'h2) && result[31].
  - mag = neg ? (~result + 1) : result, computed mod 2^32. Signed 0x8000_0000 gives mag 0x8000_0000 and is sent as "-80000000".
  - busy goes to 1 on the next edge.
- Overrun: alu_done=1 while busy=1 is ignored and overrun pulses 1 on the next cycle. The in-flight line is not disturbed.
- Handshake:
  - A byte transfers on a rising edge where tx_valid && tx_ready.
  - tx_valid and tx_data are registered and stay stable until that transfer.
  - tx_valid never deasserts without a transfer, except on reset.
- State machine:
  - IDLE --alu_done--> SIGN if neg, else DIGIT (idx=7).
  - SIGN: present 8'h2D ('-'); on transfer go to DIGIT, idx=7.
  - DIGIT: nibble = mag[4*idx+3 -: 4].
    - If LZ_SUPPRESS, nibble==0, no nonzero digit seen yet, and idx!=0: skip the digit. The skip takes one cycle with tx_valid=0, then idx decrements.
    - Otherwise present ASCII: 0-9 map to 8'h30..39; A-F per UPPER_HEX. Set the nonzero-seen flag.
    - On transfer: if idx==0 go to CR, else decrement idx.
  - CR: present 8'h0D; on transfer go to LF.
  - LF: present 8'h0A; on transfer go to IDLE. busy drops on that edge.
- Latency:
  - tx_valid rises on the first edge after alu_done for the '-' or first-sent digit. Each suppressed leading zero adds one cycle.
  - With tx_ready held 1, consecutive bytes go out on consecutive cycles.
- A new alu_done is accepted in the same cycle that IDLE is entered. It is not accepted on the LF transfer edge itself, because busy is still 1 then and an overrun is flagged.
- Byte count per line: (neg?1:0) + digits + 2, where digits is 1..8.

Decomposition:
- Shared calc package: dtype codes (DT_UNSIGNED=4'h1, DT_SIGNED=4'h2), ASCII constants (CR, LF, MINUS, '0', 'A'), and the FSM state encoding (IDLE, SIGN, DIGIT, CR, LF).
- One sub-module, hex2ascii: combinational 4-bit nibble to 8-bit ASCII, with UPPER_HEX passed through. The FSM, capture register and handshake stay in alu_result_fmt.

Test Plan:
- Unsigned 0x0000_1234, dtype 4'h1, LZ_SUPPRESS=1, tx_ready=1:
  - bytes 31 32 33 34 0D 0A;
  - first tx_valid 5 cycles after alu_done (4 skips);
  - busy low after 0A.
- Signed 0xFFFF_FFFE, dtype 4'h2: bytes 2D 32 0D 0A. Also signed 0x8000_0000: bytes 2D 38 30 30 30 30 30 30 30 0D 0A.
- Result 0x0000_0000, LZ_SUPPRESS=1: bytes 30 0D 0A. With LZ_SUPPRESS=0, 0xDEAD_BEEF, UPPER_HEX=0: bytes 64 65 61 64 62 65 65 66 0D 0A.
- tx_ready toggled randomly (1 of 3 cycles high) on 0x0000_00AB: tx_data and tx_valid are stable while ready=0; exactly 41 42 0D 0A are transferred, with no duplicates or drops.
- alu_done pulsed again 2 cycles into a line: overrun is 1 for exactly one cycle, and the original line completes unchanged. An alu_done in the first IDLE cycle after LF starts a new line.
- rst asserted while DIGIT idx=4: outputs go to reset values immediately. The next alu_done with 0x0000_0007 yields bytes 37 0D 0A only.

Source files
------------

// File: rtl/alu_result_fmt_pkg.sv
// Shared definitions for the ALU result formatter: dtype codes, ASCII bytes
// and the line-emission state encoding.
package alu_result_fmt_pkg;

    localparam logic [3:0] DT_UNSIGNED = 4'h1;
    localparam logic [3:0] DT_SIGNED   = 4'h2;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_MINUS   = 8'h2D;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } fmt_state_t;

endpackage

// File: rtl/alu_result_fmt_hex2ascii.sv
// Combinational nibble-to-ASCII converter; UPPER_HEX picks the A-F or a-f range.
module hex2ascii
    import alu_result_fmt_pkg::*;
#(
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    logic [7:0] w_alpha_base;

    assign w_alpha_base = UPPER_HEX ? ASCII_UPPER_A : ASCII_LOWER_A;
    assign o_ascii = (i_nibble < 4'd10) ? (ASCII_ZERO + {4'h0, i_nibble})
                                        : (w_alpha_base + {4'h0, i_nibble} - 8'd10);

endmodule

// File: rtl/alu_result_fmt.sv
// Captures an ALU result and streams it to the UART TX as an ASCII hex line
// ("-"? digits CR LF) over a registered valid/ready handshake.
module alu_result_fmt
    import alu_result_fmt_pkg::*;
#(
    parameter bit LZ_SUPPRESS = 1'b1,
    parameter bit UPPER_HEX   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_done,
    input  logic [31:0] result,
    input  logic [3:0]  dtype,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        overrun
);

    fmt_state_t  r_state;
    logic [31:0] r_mag;
    logic [2:0]  r_idx;
    logic        r_nz;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_overrun;

    logic        w_cap_neg;
    logic [31:0] w_cap_mag;
    logic        w_xfer;
    logic [31:0] w_eval_mag;
    logic [2:0]  w_eval_idx;
    logic        w_eval_seen;
    logic [3:0]  w_eval_nib;
    logic        w_eval_skip;
    logic [7:0]  w_eval_ascii;

    assign w_cap_neg = (dtype == DT_SIGNED) && result[31];
    assign w_cap_mag = w_cap_neg ? (~result + 32'd1) : result;
    assign w_xfer    = r_tx_valid && tx_ready;

    // Look ahead at the digit to be presented after this edge, so the first
    // digit can be registered on the capture edge itself.
    always_comb begin
        w_eval_mag = r_mag;
        w_eval_idx = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_eval_mag = w_cap_mag;
                w_eval_idx = 3'd7;
            end
            ST_SIGN:  w_eval_idx = 3'd7;
            ST_DIGIT: w_eval_idx = r_idx - 3'd1;
            default:  ;
        endcase
    end

    assign w_eval_seen = (r_state == ST_DIGIT) && r_nz;
    assign w_eval_nib  = w_eval_mag[{w_eval_idx, 2'b00} +: 4];
    assign w_eval_skip = LZ_SUPPRESS && (w_eval_nib == 4'h0) && !w_eval_seen
                         && (w_eval_idx != 3'd0);

    hex2ascii #(
        .UPPER_HEX(UPPER_HEX)
    ) u_hex2ascii (
        .i_nibble(w_eval_nib),
        .o_ascii (w_eval_ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mag      <= 32'd0;
            r_idx      <= 3'd0;
            r_nz       <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= alu_done && r_busy;
            case (r_state)
                ST_IDLE: begin
                    if (alu_done) begin
                        r_mag  <= w_cap_mag;
                        r_busy <= 1'b1;
                        r_idx  <= 3'd7;
                        r_nz   <= !w_cap_neg && !w_eval_skip;
                        if (w_cap_neg) begin
                            r_state    <= ST_SIGN;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ASCII_MINUS;
                        end else begin
                            r_state    <= ST_DIGIT;
                            r_tx_valid <= !w_eval_skip;
                            r_tx_data  <= w_eval_ascii;
                        end
                    end
                end
                ST_SIGN: begin
                    if (w_xfer) begin
                        r_state    <= ST_DIGIT;
                        r_idx      <= 3'd7;
                        r_tx_valid <= !w_eval_skip;
                        r_tx_data  <= w_eval_ascii;
                        r_nz       <= !w_eval_skip;
                    end
                end
                ST_DIGIT: begin
                    // tx_valid low here means the previous cycle was a skipped zero
                    if (!r_tx_valid || (w_xfer && (r_idx != 3'd0))) begin
                        r_idx      <= w_eval_idx;
                        r_tx_valid <= !w_eval_skip;
                        r_tx_data  <= w_eval_ascii;
                        r_nz       <= r_nz || !w_eval_skip;
                    end else if (w_xfer) begin
                        r_state   <= ST_CR;
                        r_tx_data <= ASCII_CR;
                    end
                end
                ST_CR: begin
                    if (w_xfer) begin
                        r_state   <= ST_LF;
                        r_tx_data <= ASCII_LF;
                    end
                end
                ST_LF: begin
                    if (w_xfer) begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule
